// File: rtl/encoder8_3_stream.sv
// encoder8_3_stream: registered 8-to-3 one-hot encoder with a 2-entry
// valid/ready output buffer and a saturating malformed-word counter.
// Result = index of the highest set bit; err flags any word that is not
// exactly one-hot (including all-zero, which encodes as 0).
module encoder8_3_stream #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [7:0]       in_data,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [2:0]       out_code,
  output logic             out_err,
  input  logic             out_rdy,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  // Buffer occupancy doubles as the state encoding (value == entry count).
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } occ_t;

  localparam logic [CNT_W-1:0] ERR_MAX = '1;
  localparam logic [CNT_W-1:0] ERR_ONE = CNT_W'(1);

  occ_t             r_state;
  occ_t             w_state_nxt;

  logic [2:0]       r_code_q [2];
  logic             r_err_q  [2];
  logic             r_wptr;
  logic             r_rptr;

  logic [2:0]       r_last_code;
  logic             r_last_err;

  logic [CNT_W-1:0] r_err_cnt;

  logic [2:0]       w_enc_code;
  logic             w_enc_err;
  logic [3:0]       w_ones;

  logic             w_push;
  logic             w_pop;
  logic [2:0]       w_head_code;
  logic             w_head_err;

  // Handshake decode: ready/valid come from registered occupancy only.
  always_comb begin
    in_rdy  = (r_state != S_FULL);
    out_vld = (r_state != S_EMPTY);
    w_push  = in_vld && in_rdy;
    w_pop   = out_vld && out_rdy;
  end

  // Encoder: later (higher) set bits override earlier ones, giving the
  // highest-index bit; popcount != 1 marks the word as malformed.
  always_comb begin
    w_enc_code = '0;
    w_ones     = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (in_data[i]) begin
        w_enc_code = i[2:0];
        w_ones     = w_ones + 4'd1;
      end
    end
    w_enc_err = (w_ones != 4'd1);
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Occupancy next-state: push and pop together leave the count unchanged
  // (only possible with one entry, since full blocks push and empty blocks pop).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_EMPTY: begin
        if (w_push) w_state_nxt = S_ONE;
      end
      S_ONE: begin
        if (w_push && !w_pop)      w_state_nxt = S_FULL;
        else if (w_pop && !w_push) w_state_nxt = S_EMPTY;
      end
      S_FULL: begin
        if (w_pop) w_state_nxt = S_ONE;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Storage and wrapping 1-bit pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_code_q[0] <= '0;
      r_code_q[1] <= '0;
      r_err_q[0]  <= 1'b0;
      r_err_q[1]  <= 1'b0;
    end else begin
      if (w_push) begin
        r_code_q[r_wptr] <= w_enc_code;
        r_err_q[r_wptr]  <= w_enc_err;
        r_wptr           <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
    end
  end

  // Last popped result, shown while the buffer is empty (the slot under the
  // read pointer may hold an older, stale entry at that point).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_code <= '0;
      r_last_err  <= 1'b0;
    end else if (w_pop) begin
      r_last_code <= w_head_code;
      r_last_err  <= w_head_err;
    end
  end

  // Head-of-buffer view driven onto the output.
  always_comb begin
    w_head_code = r_code_q[r_rptr];
    w_head_err  = r_err_q[r_rptr];
    if (r_state == S_EMPTY) begin
      out_code = r_last_code;
      out_err  = r_last_err;
    end else begin
      out_code = w_head_code;
      out_err  = w_head_err;
    end
  end

  // Saturating malformed-word counter; a clear in the same cycle as a
  // malformed push restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= (w_push && w_enc_err) ? ERR_ONE : '0;
    end else if (w_push && w_enc_err && (r_err_cnt != ERR_MAX)) begin
      r_err_cnt <= r_err_cnt + ERR_ONE;
    end
  end

  assign err_cnt = r_err_cnt;

endmodule
